// File: rtl/spd_pkg.sv
// Shared constants and types for the serial pattern detector.
// No logic; latency and backpressure are defined by the modules that import it.
package spd_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_W-1:0] DEF_PATTERN = 4'b1101;
  localparam logic             DEF_OVERLAP = 1'b1;

  // Fill counter must hold 0..W inclusive.
  localparam int FILL_W = $clog2(DEF_W + 1);

  typedef enum logic {
    MODE_DISJOINT = 1'b0,
    MODE_OVERLAP  = 1'b1
  } match_mode_e;

  function automatic int fill_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Bit-stream, configuration and status bundle for the serial pattern detector.
// Pure wiring: no latency; the source may stall simply by holding in_valid low.
interface serial_pattern_detector_if
  import spd_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             x;
  logic             cfg_load;
  logic [W-1:0]     cfg_pattern;
  logic             cfg_overlap;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output in_valid,
    output x,
    output cfg_load,
    output cfg_pattern,
    output cfg_overlap,
    input  z,
    input  match_cnt,
    input  armed
  );

  modport slave (
    input  in_valid,
    input  x,
    input  cfg_load,
    input  cfg_pattern,
    input  cfg_overlap,
    output z,
    output match_cnt,
    output armed
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// One-cycle update latency; no backpressure, inc is honoured every cycle clr is low.
module sat_counter
  import spd_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Matches the last W accepted bits of x against a loadable pattern, pulses z and counts hits.
// z is registered one cycle after the sampling edge; in_valid low simply stalls the history.
module serial_pattern_detector
  import spd_pkg::*;
#(
  parameter int           W           = DEF_W,
  parameter int           CNT_W       = DEF_CNT_W,
  parameter logic [W-1:0] RST_PATTERN = W'(DEF_PATTERN),
  parameter logic         RST_OVERLAP = DEF_OVERLAP
) (
  input  logic                       clk,
  input  logic                       resetn,
  serial_pattern_detector_if.slave   bus
);

  localparam int                    FILL_WIDTH = fill_width(W);
  localparam logic [FILL_WIDTH-1:0] FILL_MAX   = FILL_WIDTH'(W);
  localparam logic [FILL_WIDTH:0]   FILL_LIM   = (FILL_WIDTH + 1)'(W);

  logic [W-1:0]          pattern_q;
  match_mode_e           mode_q;
  logic [W-1:0]          hist_q;
  logic [W-1:0]          hist_d;
  logic [W-1:0]          nh;
  logic [FILL_WIDTH-1:0] fill_q;
  logic [FILL_WIDTH-1:0] fill_d;
  logic [FILL_WIDTH:0]   fill_inc;
  logic                  accept;
  logic                  hit;
  logic                  z_q;
  logic                  armed_q;
  logic [CNT_W-1:0]      cnt;

  // A bit arriving together with cfg_load belongs to the old configuration and is dropped.
  assign accept = bus.in_valid & ~bus.cfg_load;

  always_comb begin
    nh       = {hist_q[W-2:0], bus.x};
    fill_inc = {1'b0, fill_q} + (FILL_WIDTH + 1)'(1);
    hit      = accept && (nh == pattern_q) && (fill_inc >= FILL_LIM);
    hist_d   = hist_q;
    fill_d   = fill_q;

    if (bus.cfg_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = nh;
      if (hit) begin
        // Non-overlap mode forgets the matched bits so the next hit needs W fresh ones.
        fill_d = (mode_q == MODE_OVERLAP) ? FILL_MAX : '0;
      end else if (fill_inc >= FILL_LIM) begin
        fill_d = FILL_MAX;
      end else begin
        fill_d = fill_inc[FILL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pattern_q <= RST_PATTERN;
      mode_q    <= match_mode_e'(RST_OVERLAP);
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        pattern_q <= bus.cfg_pattern;
        mode_q    <= match_mode_e'(bus.cfg_overlap);
      end
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      z_q     <= hit;
      armed_q <= (fill_d == FILL_MAX);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.cfg_load),
    .inc    (hit),
    .cnt    (cnt)
  );

  assign bus.z         = z_q;
  assign bus.match_cnt = cnt;
  assign bus.armed     = armed_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: one 8-bit-counter instance and one 2-bit-counter instance.
module tb_serial_pattern_detector;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_pattern_detector_if #(.W(4), .CNT_W(8)) a_if ();
  serial_pattern_detector_if #(.W(4), .CNT_W(2)) b_if ();

  serial_pattern_detector #(
    .W(4), .CNT_W(8), .RST_PATTERN(4'b1101), .RST_OVERLAP(1'b1)
  ) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (a_if)
  );

  serial_pattern_detector #(
    .W(4), .CNT_W(2), .RST_PATTERN(4'b1101), .RST_OVERLAP(1'b1)
  ) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic b);
    a_if.in_valid = v;
    a_if.x        = b;
    a_if.cfg_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input logic [3:0] pat, input logic ov, input logic v, input logic b);
    a_if.cfg_load    = 1'b1;
    a_if.cfg_pattern = pat;
    a_if.cfg_overlap = ov;
    a_if.in_valid    = v;
    a_if.x           = b;
    @(posedge clk);
    #1;
    a_if.cfg_load = 1'b0;
    a_if.in_valid = 1'b0;
  endtask

  // Feeds n valid bits, MSB first, checking z after every sampling edge.
  task automatic feed_a(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] zexp);
    for (int i = n - 1; i >= 0; i--) begin
      step_a(1'b1, bits[i]);
      chk(tag, {31'b0, a_if.z}, {31'b0, zexp[i]});
    end
  endtask

  task automatic step_b(input logic v, input logic b);
    b_if.in_valid = v;
    b_if.x        = b;
    b_if.cfg_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    a_if.in_valid = 1'b0; a_if.x = 1'b0; a_if.cfg_load = 1'b0;
    a_if.cfg_pattern = 4'b0000; a_if.cfg_overlap = 1'b0;
    b_if.in_valid = 1'b0; b_if.x = 1'b0; b_if.cfg_load = 1'b0;
    b_if.cfg_pattern = 4'b0000; b_if.cfg_overlap = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", {31'b0, a_if.z}, 32'd0);
    chk("rst_cnt", {24'b0, a_if.match_cnt}, 32'd0);
    chk("rst_armed", {31'b0, a_if.armed}, 32'd0);
    resetn = 1'b1;

    // Default pattern 1101 with overlap: hits on bits 4 and 7.
    feed_a("t1_z", 16'b1101101, 7, 16'b0001001);
    chk("t1_cnt", {24'b0, a_if.match_cnt}, 32'd2);
    chk("t1_armed", {31'b0, a_if.armed}, 32'd1);

    // 1111 without overlap: hits on bits 4 and 8.
    cfg_a(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("t2_load_cnt", {24'b0, a_if.match_cnt}, 32'd0);
    chk("t2_load_armed", {31'b0, a_if.armed}, 32'd0);
    feed_a("t2_noov_z", 16'hFF, 8, 16'b00010001);
    chk("t2_noov_cnt", {24'b0, a_if.match_cnt}, 32'd2);

    // 1111 with overlap: hits on bits 4..8.
    cfg_a(4'b1111, 1'b1, 1'b0, 1'b0);
    feed_a("t2_ov_z", 16'hFF, 8, 16'b00011111);
    chk("t2_ov_cnt", {24'b0, a_if.match_cnt}, 32'd5);

    // Idle cycles with toggling x must not enter the history.
    cfg_a(4'b1101, 1'b1, 1'b0, 1'b0);
    feed_a("t3_pre_z", 16'b11, 2, 16'b00);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b0, i[0]);
      chk("t3_idle_z", {31'b0, a_if.z}, 32'd0);
    end
    feed_a("t3_post_z", 16'b01, 2, 16'b01);
    chk("t3_cnt", {24'b0, a_if.match_cnt}, 32'd1);

    // cfg_load wins over a same-cycle valid bit and restarts detection.
    cfg_a(4'b1101, 1'b1, 1'b0, 1'b0);
    feed_a("t4_pre_z", 16'b110, 3, 16'b000);
    cfg_a(4'b1101, 1'b1, 1'b1, 1'b1);
    chk("t4_load_z", {31'b0, a_if.z}, 32'd0);
    chk("t4_load_cnt", {24'b0, a_if.match_cnt}, 32'd0);
    chk("t4_load_armed", {31'b0, a_if.armed}, 32'd0);
    feed_a("t4_post_z", 16'b110, 3, 16'b000);
    chk("t4_armed3", {31'b0, a_if.armed}, 32'd0);
    step_a(1'b1, 1'b1);
    chk("t4_hit_z", {31'b0, a_if.z}, 32'd1);
    chk("t4_cnt", {24'b0, a_if.match_cnt}, 32'd1);
    chk("t4_armed4", {31'b0, a_if.armed}, 32'd1);

    // Reset mid-stream restores pattern 1101 and overlap mode.
    cfg_a(4'b0000, 1'b0, 1'b0, 1'b0);
    feed_a("t6_pre_z", 16'b110, 3, 16'b000);
    resetn = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.x = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_z", {31'b0, a_if.z}, 32'd0);
    chk("t6_rst_cnt", {24'b0, a_if.match_cnt}, 32'd0);
    chk("t6_rst_armed", {31'b0, a_if.armed}, 32'd0);
    resetn = 1'b1;
    feed_a("t6_first_z", 16'b1, 1, 16'b0);
    feed_a("t6_pat_z", 16'b101, 3, 16'b001);
    feed_a("t6_ov_z", 16'b101, 3, 16'b001);
    chk("t6_cnt", {24'b0, a_if.match_cnt}, 32'd2);
    a_if.in_valid = 1'b0;

    // 2-bit counter saturates at 3 while z keeps pulsing.
    b_if.cfg_load = 1'b1;
    b_if.cfg_pattern = 4'b1111;
    b_if.cfg_overlap = 1'b1;
    @(posedge clk);
    #1;
    b_if.cfg_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step_b(1'b1, 1'b1);
      chk("t5_z", {31'b0, b_if.z}, (k >= 4) ? 32'd1 : 32'd0);
      chk("t5_cnt", {30'b0, b_if.match_cnt},
          (k <= 3) ? 32'd0 : ((k - 3 > 3) ? 32'd3 : 32'(k - 3)));
    end
    b_if.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
